// File: rtl/sys_defs.sv
// Shared core-wide sizes and packet types for rename, free list and writeback.
package sys_defs;
  localparam int N_LANES     = 2;
  localparam int ARCH_REG_SZ = 32;
  localparam int PHYS_REG_SZ = 256;

  typedef logic [$clog2(PHYS_REG_SZ)-1:0] PRN;

  typedef struct packed {
    logic valid;
    PRN   prn;
  } FREE_LIST_PACKET;

  typedef struct packed {
    logic valid;
    PRN   prn;
  } CDB_PACKET;
endpackage

// File: rtl/rename_bypass.sv
// Intra-group dependency resolution: sources and displaced dest mappings of a lane
// are overridden by dests allocated in lower accepted lanes of the same group.
module rename_bypass
  import sys_defs::*;
#(
  parameter int N  = N_LANES,
  parameter int AW = $clog2(ARCH_REG_SZ)
) (
  input  logic [N-1:0]         rename_accept,
  input  logic [N-1:0][AW-1:0] rename_dest,
  input  logic [N-1:0][AW-1:0] rename_src1,
  input  logic [N-1:0][AW-1:0] rename_src2,
  input  PRN   [N-1:0]         new_prn,
  input  PRN   [N-1:0]         tbl_src1_prn,
  input  PRN   [N-1:0]         tbl_src2_prn,
  input  logic [N-1:0]         tbl_src1_ready,
  input  logic [N-1:0]         tbl_src2_ready,
  input  PRN   [N-1:0]         tbl_old_prn,
  output PRN   [N-1:0]         src1_prn,
  output PRN   [N-1:0]         src2_prn,
  output logic [N-1:0]         src1_ready,
  output logic [N-1:0]         src2_ready,
  output PRN   [N-1:0]         old_prn
);

  always_comb begin
    src1_prn   = '0;
    src2_prn   = '0;
    src1_ready = '0;
    src2_ready = '0;
    old_prn    = '0;
    for (int j = 0; j < N; j++) begin
      if (rename_accept[j]) begin
        src1_prn[j]   = tbl_src1_prn[j];
        src2_prn[j]   = tbl_src2_prn[j];
        src1_ready[j] = tbl_src1_ready[j];
        src2_ready[j] = tbl_src2_ready[j];
        old_prn[j]    = tbl_old_prn[j];
        // Ascending scan so the highest matching lower lane wins.
        for (int i = 0; i < j; i++) begin
          if (rename_accept[i] && (rename_dest[i] != '0)) begin
            if (rename_dest[i] == rename_src1[j]) begin
              src1_prn[j]   = new_prn[i];
              src1_ready[j] = 1'b0;
            end
            if (rename_dest[i] == rename_src2[j]) begin
              src2_prn[j]   = new_prn[i];
              src2_ready[j] = 1'b0;
            end
            if (rename_dest[i] == rename_dest[j]) begin
              old_prn[j] = new_prn[i];
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/map_table.sv
// Speculative register alias table: N-wide rename with in-order lane acceptance,
// CDB readiness tracking, and squash recovery from the committed map.
module map_table
  import sys_defs::*;
#(
  parameter  int N       = N_LANES,
  parameter  int ARCH_SZ = ARCH_REG_SZ,
  localparam int AW      = $clog2(ARCH_SZ)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N-1:0]           rename_valid,
  input  logic [N-1:0][AW-1:0]   rename_dest,
  input  logic [N-1:0][AW-1:0]   rename_src1,
  input  logic [N-1:0][AW-1:0]   rename_src2,
  input  FREE_LIST_PACKET [N-1:0] fl_pop_packet,
  output logic [N-1:0]           fl_pop_en,
  output logic [N-1:0]           rename_accept,
  output PRN   [N-1:0]           src1_prn,
  output PRN   [N-1:0]           src2_prn,
  output logic [N-1:0]           src1_ready,
  output logic [N-1:0]           src2_ready,
  output PRN   [N-1:0]           dest_prn,
  output PRN   [N-1:0]           old_prn,
  input  CDB_PACKET [N-1:0]      cdb_packet,
  input  logic                   squash,
  input  PRN   [ARCH_SZ-1:0]     rrat_map
);

  PRN   [ARCH_SZ-1:0] map_q, map_d;
  logic [ARCH_SZ-1:0] ready_q, ready_d;

  PRN   [N-1:0] new_prn;
  PRN   [N-1:0] tbl_src1_prn, tbl_src2_prn, tbl_old_prn;
  logic [N-1:0] tbl_src1_ready, tbl_src2_ready;

  // A rejected valid lane blocks every higher lane so renaming stays in program order.
  always_comb begin
    logic blocked;
    blocked       = 1'b0;
    fl_pop_en     = '0;
    rename_accept = '0;
    new_prn       = '0;
    for (int i = 0; i < N; i++) begin
      if (!reset && !squash && rename_valid[i]) begin
        fl_pop_en[i] = (rename_dest[i] != '0);
        if (!blocked && ((rename_dest[i] == '0) || fl_pop_packet[i].valid)) begin
          rename_accept[i] = 1'b1;
        end else begin
          blocked = 1'b1;
        end
      end
      if (rename_accept[i] && (rename_dest[i] != '0)) begin
        new_prn[i] = fl_pop_packet[i].prn;
      end
    end
  end

  always_comb begin
    tbl_src1_prn   = '0;
    tbl_src2_prn   = '0;
    tbl_src1_ready = '0;
    tbl_src2_ready = '0;
    tbl_old_prn    = '0;
    for (int i = 0; i < N; i++) begin
      tbl_src1_prn[i]   = map_q[rename_src1[i]];
      tbl_src2_prn[i]   = map_q[rename_src2[i]];
      tbl_src1_ready[i] = ready_q[rename_src1[i]];
      tbl_src2_ready[i] = ready_q[rename_src2[i]];
      tbl_old_prn[i]    = map_q[rename_dest[i]];
      for (int k = 0; k < N; k++) begin
        if (cdb_packet[k].valid && (cdb_packet[k].prn == tbl_src1_prn[i])) tbl_src1_ready[i] = 1'b1;
        if (cdb_packet[k].valid && (cdb_packet[k].prn == tbl_src2_prn[i])) tbl_src2_ready[i] = 1'b1;
      end
    end
  end

  rename_bypass #(
    .N  (N),
    .AW (AW)
  ) u_rename_bypass (
    .rename_accept  (rename_accept),
    .rename_dest    (rename_dest),
    .rename_src1    (rename_src1),
    .rename_src2    (rename_src2),
    .new_prn        (new_prn),
    .tbl_src1_prn   (tbl_src1_prn),
    .tbl_src2_prn   (tbl_src2_prn),
    .tbl_src1_ready (tbl_src1_ready),
    .tbl_src2_ready (tbl_src2_ready),
    .tbl_old_prn    (tbl_old_prn),
    .src1_prn       (src1_prn),
    .src2_prn       (src2_prn),
    .src1_ready     (src1_ready),
    .src2_ready     (src2_ready),
    .old_prn        (old_prn)
  );

  assign dest_prn = new_prn;

  // Renames are applied after CDB wakeups so a same-cycle rename clears readiness.
  always_comb begin
    map_d   = map_q;
    ready_d = ready_q;
    if (squash) begin
      map_d   = rrat_map;
      ready_d = '1;
    end else begin
      for (int e = 0; e < ARCH_SZ; e++) begin
        for (int k = 0; k < N; k++) begin
          if (cdb_packet[k].valid && (cdb_packet[k].prn == map_q[e])) ready_d[e] = 1'b1;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (rename_accept[i] && (rename_dest[i] != '0)) begin
          map_d[rename_dest[i]]   = new_prn[i];
          ready_d[rename_dest[i]] = 1'b0;
        end
      end
    end
    map_d[0]   = '0;
    ready_d[0] = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ARCH_SZ; i++) begin
        map_q[i] <= PRN'(i);
      end
      ready_q <= '1;
    end else begin
      map_q   <= map_d;
      ready_q <= ready_d;
    end
  end

endmodule

// File: tb/tb_map_table.sv
// Directed bench for map_table: reset, rename, intra-group bypass, stalls, CDB and squash.
module tb_map_table;
  import sys_defs::*;

  localparam int N  = 2;
  localparam int AS = 32;
  localparam int AW = 5;

  logic                   clock, reset, squash;
  logic [N-1:0]           rename_valid;
  logic [N-1:0][AW-1:0]   rename_dest, rename_src1, rename_src2;
  FREE_LIST_PACKET [N-1:0] fl_pop_packet;
  logic [N-1:0]           fl_pop_en, rename_accept, src1_ready, src2_ready;
  PRN   [N-1:0]           src1_prn, src2_prn, dest_prn, old_prn;
  CDB_PACKET [N-1:0]      cdb_packet;
  PRN   [AS-1:0]          rrat_map;

  int vecs = 0;
  int errs = 0;

  map_table #(.N(N), .ARCH_SZ(AS)) dut (
    .clock         (clock),
    .reset         (reset),
    .rename_valid  (rename_valid),
    .rename_dest   (rename_dest),
    .rename_src1   (rename_src1),
    .rename_src2   (rename_src2),
    .fl_pop_packet (fl_pop_packet),
    .fl_pop_en     (fl_pop_en),
    .rename_accept (rename_accept),
    .src1_prn      (src1_prn),
    .src2_prn      (src2_prn),
    .src1_ready    (src1_ready),
    .src2_ready    (src2_ready),
    .dest_prn      (dest_prn),
    .old_prn       (old_prn),
    .cdb_packet    (cdb_packet),
    .squash        (squash),
    .rrat_map      (rrat_map)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic idle();
    rename_valid  = '0;
    rename_dest   = '0;
    rename_src1   = '0;
    rename_src2   = '0;
    fl_pop_packet = '0;
    cdb_packet    = '0;
    squash        = 1'b0;
  endtask

  task automatic lane(input int i, input logic [AW-1:0] d, input logic [AW-1:0] s1,
                      input logic [AW-1:0] s2, input logic pv, input PRN p);
    rename_valid[i]  = 1'b1;
    rename_dest[i]   = d;
    rename_src1[i]   = s1;
    rename_src2[i]   = s2;
    fl_pop_packet[i] = {pv, p};
  endtask

  // Lane 0 with no destination exposes the table contents for two registers.
  task automatic peek(input logic [AW-1:0] a, input logic [AW-1:0] b);
    idle();
    lane(0, 5'd0, a, b, 1'b0, 8'd0);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    lane(0, 5'd3, 5'd1, 5'd2, 1'b1, 8'd9);
    lane(1, 5'd0, 5'd1, 5'd2, 1'b0, 8'd0);
    #1;
    vecs++; if (rename_accept !== 2'b00) begin errs++; $display("FAIL reset_accept: got %b want 00", rename_accept); end
    vecs++; if (fl_pop_en !== 2'b00) begin errs++; $display("FAIL reset_pop_en: got %b want 00", fl_pop_en); end
    @(negedge clock);
    reset = 1'b0;
    peek(5'd1, 5'd31);
    vecs++; if (rename_accept !== 2'b01) begin errs++; $display("FAIL reset_peek_accept: got %b want 01", rename_accept); end
    vecs++; if ({src1_prn[0], src1_ready[0]} !== {8'd1, 1'b1}) begin errs++; $display("FAIL reset_map1: got %0h/%b want 1/1", src1_prn[0], src1_ready[0]); end
    vecs++; if ({src2_prn[0], src2_ready[0]} !== {8'd31, 1'b1}) begin errs++; $display("FAIL reset_map31: got %0h/%b want 1f/1", src2_prn[0], src2_ready[0]); end
    vecs++; if ({dest_prn[0], old_prn[0]} !== 16'h0000) begin errs++; $display("FAIL dest0_prns: got %0h/%0h want 0/0", dest_prn[0], old_prn[0]); end
  endtask

  task automatic test_basic();
    @(negedge clock);
    idle();
    lane(0, 5'd1, 5'd2, 5'd3, 1'b1, 8'd32);
    #1;
    vecs++; if (rename_accept !== 2'b01) begin errs++; $display("FAIL basic_accept: got %b want 01", rename_accept); end
    vecs++; if (fl_pop_en !== 2'b01) begin errs++; $display("FAIL basic_pop_en: got %b want 01", fl_pop_en); end
    vecs++; if ({src1_prn[0], src1_ready[0]} !== {8'd2, 1'b1}) begin errs++; $display("FAIL basic_src1: got %0d/%b want 2/1", src1_prn[0], src1_ready[0]); end
    vecs++; if ({src2_prn[0], src2_ready[0]} !== {8'd3, 1'b1}) begin errs++; $display("FAIL basic_src2: got %0d/%b want 3/1", src2_prn[0], src2_ready[0]); end
    vecs++; if ({dest_prn[0], old_prn[0]} !== {8'd32, 8'd1}) begin errs++; $display("FAIL basic_dest_old: got %0d/%0d want 32/1", dest_prn[0], old_prn[0]); end
    @(negedge clock);
    peek(5'd1, 5'd0);
    vecs++; if ({src1_prn[0], src1_ready[0]} !== {8'd32, 1'b0}) begin errs++; $display("FAIL basic_map1: got %0d/%b want 32/0", src1_prn[0], src1_ready[0]); end
    vecs++; if ({src2_prn[0], src2_ready[0]} !== {8'd0, 1'b1}) begin errs++; $display("FAIL basic_map0: got %0d/%b want 0/1", src2_prn[0], src2_ready[0]); end
  endtask

  task automatic test_bypass();
    @(negedge clock);
    idle();
    lane(0, 5'd5, 5'd0, 5'd0, 1'b1, 8'd40);
    lane(1, 5'd6, 5'd5, 5'd5, 1'b1, 8'd41);
    #1;
    vecs++; if (rename_accept !== 2'b11) begin errs++; $display("FAIL byp_accept: got %b want 11", rename_accept); end
    vecs++; if ({src1_prn[1], src1_ready[1]} !== {8'd40, 1'b0}) begin errs++; $display("FAIL byp_src1: got %0d/%b want 40/0", src1_prn[1], src1_ready[1]); end
    vecs++; if ({src2_prn[1], src2_ready[1]} !== {8'd40, 1'b0}) begin errs++; $display("FAIL byp_src2: got %0d/%b want 40/0", src2_prn[1], src2_ready[1]); end
    vecs++; if ({dest_prn[1], old_prn[1], old_prn[0]} !== {8'd41, 8'd6, 8'd5}) begin errs++; $display("FAIL byp_dest_old: got %0d/%0d/%0d want 41/6/5", dest_prn[1], old_prn[1], old_prn[0]); end
    @(negedge clock);
    peek(5'd5, 5'd6);
    vecs++; if ({src1_prn[0], src1_ready[0]} !== {8'd40, 1'b0}) begin errs++; $display("FAIL byp_map5: got %0d/%b want 40/0", src1_prn[0], src1_ready[0]); end
    vecs++; if ({src2_prn[0], src2_ready[0]} !== {8'd41, 1'b0}) begin errs++; $display("FAIL byp_map6: got %0d/%b want 41/0", src2_prn[0], src2_ready[0]); end
  endtask

  task automatic test_same_dest();
    @(negedge clock);
    idle();
    lane(0, 5'd7, 5'd1, 5'd2, 1'b1, 8'd50);
    lane(1, 5'd7, 5'd7, 5'd0, 1'b1, 8'd51);
    #1;
    vecs++; if ({old_prn[0], old_prn[1]} !== {8'd7, 8'd50}) begin errs++; $display("FAIL same_old: got %0d/%0d want 7/50", old_prn[0], old_prn[1]); end
    vecs++; if ({src1_prn[1], src1_ready[1]} !== {8'd50, 1'b0}) begin errs++; $display("FAIL same_src1: got %0d/%b want 50/0", src1_prn[1], src1_ready[1]); end
    vecs++; if ({src1_prn[0], src1_ready[0]} !== {8'd32, 1'b0}) begin errs++; $display("FAIL same_l0src1: got %0d/%b want 32/0", src1_prn[0], src1_ready[0]); end
    @(negedge clock);
    peek(5'd7, 5'd0);
    vecs++; if ({src1_prn[0], src1_ready[0]} !== {8'd51, 1'b0}) begin errs++; $display("FAIL same_map7: got %0d/%b want 51/0", src1_prn[0], src1_ready[0]); end
  endtask

  task automatic test_stall();
    @(negedge clock);
    idle();
    lane(0, 5'd8, 5'd0, 5'd0, 1'b1, 8'd60);
    lane(1, 5'd9, 5'd8, 5'd0, 1'b0, 8'd61);
    #1;
    vecs++; if (rename_accept !== 2'b01) begin errs++; $display("FAIL stall_accept: got %b want 01", rename_accept); end
    vecs++; if (fl_pop_en !== 2'b11) begin errs++; $display("FAIL stall_pop_en: got %b want 11", fl_pop_en); end
    vecs++; if ({dest_prn[1], src1_prn[1], old_prn[1]} !== 24'h0) begin errs++; $display("FAIL stall_l1_zero: got %0d/%0d/%0d want 0/0/0", dest_prn[1], src1_prn[1], old_prn[1]); end
    @(negedge clock);
    peek(5'd8, 5'd9);
    vecs++; if ({src1_prn[0], src1_ready[0]} !== {8'd60, 1'b0}) begin errs++; $display("FAIL stall_map8: got %0d/%b want 60/0", src1_prn[0], src1_ready[0]); end
    vecs++; if ({src2_prn[0], src2_ready[0]} !== {8'd9, 1'b1}) begin errs++; $display("FAIL stall_map9: got %0d/%b want 9/1", src2_prn[0], src2_ready[0]); end
    @(negedge clock);
    idle();
    lane(0, 5'd10, 5'd0, 5'd0, 1'b0, 8'd0);
    lane(1, 5'd0, 5'd3, 5'd0, 1'b0, 8'd0);
    #1;
    vecs++; if (rename_accept !== 2'b00) begin errs++; $display("FAIL stall_block: got %b want 00", rename_accept); end
    @(negedge clock);
    peek(5'd10, 5'd0);
    vecs++; if ({src1_prn[0], src1_ready[0]} !== {8'd10, 1'b1}) begin errs++; $display("FAIL stall_map10: got %0d/%b want 10/1", src1_prn[0], src1_ready[0]); end
  endtask

  task automatic test_cdb();
    @(negedge clock);
    idle();
    lane(0, 5'd0, 5'd1, 5'd0, 1'b0, 8'd0);
    cdb_packet[1] = {1'b1, 8'd32};
    #1;
    vecs++; if ({src1_prn[0], src1_ready[0]} !== {8'd32, 1'b1}) begin errs++; $display("FAIL cdb_bypass: got %0d/%b want 32/1", src1_prn[0], src1_ready[0]); end
    @(negedge clock);
    peek(5'd1, 5'd0);
    vecs++; if ({src1_prn[0], src1_ready[0]} !== {8'd32, 1'b1}) begin errs++; $display("FAIL cdb_wakeup: got %0d/%b want 32/1", src1_prn[0], src1_ready[0]); end
  endtask

  task automatic test_cdb_vs_rename();
    @(negedge clock);
    idle();
    lane(0, 5'd5, 5'd5, 5'd0, 1'b1, 8'd70);
    cdb_packet[0] = {1'b1, 8'd40};
    #1;
    vecs++; if ({src1_prn[0], src1_ready[0]} !== {8'd40, 1'b1}) begin errs++; $display("FAIL cvr_src: got %0d/%b want 40/1", src1_prn[0], src1_ready[0]); end
    vecs++; if ({dest_prn[0], old_prn[0]} !== {8'd70, 8'd40}) begin errs++; $display("FAIL cvr_dest_old: got %0d/%0d want 70/40", dest_prn[0], old_prn[0]); end
    @(negedge clock);
    peek(5'd5, 5'd0);
    vecs++; if ({src1_prn[0], src1_ready[0]} !== {8'd70, 1'b0}) begin errs++; $display("FAIL cvr_map5: got %0d/%b want 70/0", src1_prn[0], src1_ready[0]); end
  endtask

  task automatic test_squash();
    @(negedge clock);
    idle();
    for (int i = 0; i < AS; i++) rrat_map[i] = PRN'(i + 100);
    squash = 1'b1;
    lane(0, 5'd4, 5'd4, 5'd0, 1'b1, 8'd80);
    cdb_packet[0] = {1'b1, 8'd104};
    #1;
    vecs++; if (rename_accept !== 2'b00) begin errs++; $display("FAIL squash_accept: got %b want 00", rename_accept); end
    vecs++; if (fl_pop_en !== 2'b00) begin errs++; $display("FAIL squash_pop_en: got %b want 00", fl_pop_en); end
    vecs++; if (src1_prn[0] !== 8'd0) begin errs++; $display("FAIL squash_src_zero: got %0d want 0", src1_prn[0]); end
    @(negedge clock);
    peek(5'd4, 5'd0);
    vecs++; if ({src1_prn[0], src1_ready[0]} !== {8'd104, 1'b1}) begin errs++; $display("FAIL squash_map4: got %0d/%b want 104/1", src1_prn[0], src1_ready[0]); end
    vecs++; if ({src2_prn[0], src2_ready[0]} !== {8'd0, 1'b1}) begin errs++; $display("FAIL squash_map0: got %0d/%b want 0/1", src2_prn[0], src2_ready[0]); end
    @(negedge clock);
    peek(5'd4, 5'd7);
    reset = 1'b1;
    #1;
    vecs++; if (rename_accept !== 2'b00) begin errs++; $display("FAIL async_rst_accept: got %b want 00", rename_accept); end
    reset = 1'b0;
    #1;
    vecs++; if ({src1_prn[0], src1_ready[0]} !== {8'd4, 1'b1}) begin errs++; $display("FAIL async_rst_map4: got %0d/%b want 4/1", src1_prn[0], src1_ready[0]); end
    vecs++; if ({src2_prn[0], src2_ready[0]} !== {8'd7, 1'b1}) begin errs++; $display("FAIL async_rst_map7: got %0d/%b want 7/1", src2_prn[0], src2_ready[0]); end
  endtask

  initial begin
    rrat_map = '0;
    test_reset();
    test_basic();
    test_bypass();
    test_same_dest();
    test_stall();
    test_cdb();
    test_cdb_vs_rename();
    test_squash();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/map_table.md
MAP_TABLE -- requirements
Module: map_table

Interface
REQ-001 Parameter N, default `N, rename/writeback width (lanes).
REQ-002 Parameter ARCH_SZ, default `ARCH_REG_SZ, architectural register count (index width $clog2(ARCH_SZ)).
REQ-003 Port clock  in  1  sole clock; all state updates on posedge.
REQ-004 Port reset  in  1  asynchronous, active-high reset; clears state immediately, independent of clock.
REQ-005 Port rename_valid  in  N  lane i carries an instruction to rename.
REQ-006 Port rename_dest / rename_src1 / rename_src2  in  N x arch-index  architectural dest/sources per lane; dest 0 means no destination.
REQ-007 Port fl_pop_packet  in  N x FREE_LIST_PACKET  free-list pop result for lane i, same cycle.
REQ-008 Port fl_pop_en  out  N  free-list pop request per lane.
REQ-009 Port rename_accept  out  N  lane i renamed this cycle.
REQ-010 Port src1_prn, src2_prn  out  N x PRN; src1_ready, src2_ready  out  N  source mappings and readiness.
REQ-011 Port dest_prn, old_prn  out  N x PRN  new dest mapping and displaced mapping (to ROB).
REQ-012 Port cdb_packet  in  N x CDB_PACKET (valid, prn)  writeback broadcasts.
REQ-013 Port squash  in  1; rrat_map  in  ARCH_SZ x PRN  committed map used for recovery.

Function
REQ-020 State: map[ARCH_SZ] of PRN, ready bit per entry.
REQ-021 fl_pop_en[i] = rename_valid[i] && rename_dest[i] != 0, purely combinational.
REQ-022 rename_accept[i] = rename_valid[i] && all lower valid lanes accepted && (rename_dest[i] == 0 || fl_pop_packet[i].valid); first rejected lane blocks all higher lanes.
REQ-023 Accepted lane with dest: dest_prn = fl_pop_packet[i].prn; old_prn = current mapping of dest including earlier same-cycle lanes; on next edge map[dest] = dest_prn, ready = 0.
REQ-024 Dest 0 never remapped; dest_prn = old_prn = 0 for such lanes; map[0] stays PRN 0, ready 1.
REQ-025 Intra-group bypass: source of lane j matching accepted dest of lower lane i takes that lane's dest_prn with ready = 0; highest such i wins.
REQ-026 Multiple accepted lanes same dest: highest lane's PRN written to map.
REQ-027 CDB: each valid cdb_packet sets ready for every entry mapped to that PRN at next edge.
REQ-028 Same-cycle CDB bypass: source read from the table whose PRN matches a valid cdb_packet reports ready = 1.
REQ-029 Rename write in the same cycle as CDB to the same entry: rename (ready = 0) wins.
REQ-030 squash: next edge map = rrat_map, all ready = 1; rename_accept = 0 and fl_pop_en = 0 that cycle; CDB ignored.
REQ-031 Outputs for non-accepted lanes are don't-care but driven to 0.
REQ-032 Source/dest outputs combinational from current state plus current inputs; zero-cycle latency.

Reset
REQ-040 On reset assertion, asynchronously: map[i] = i, ready[i] = 1 for all i.
REQ-041 During reset, fl_pop_en = 0 and rename_accept = 0; reset mid-rename discards that group.

Structure
REQ-050 PRN, FREE_LIST_PACKET, CDB_PACKET, `N, `ARCH_REG_SZ come from the shared sys_defs package; no new typedefs local to the module.
REQ-051 No sub-module; if factored, the dependency-check logic goes in rename_bypass (combinational).

Verification
REQ-060 Reset, N=2: rename r1<-r2+r3 lane0 with pop PRN 32 -> src1_prn 2 ready 1, src2_prn 3 ready 1, dest_prn 32, old_prn 1; next cycle map[1] = 32 ready 0.
REQ-061 Lane0 r5<-..., lane1 r6<-r5+r5, pops 40/41 -> lane1 src1/src2 = 40 ready 0; old_prn lane1 = 6.
REQ-062 Both lanes dest r7, pops 50/51 -> lane1 old_prn 50; next cycle map[7] = 51.
REQ-063 Lane0 pop valid, lane1 pop invalid (free list empty) -> rename_accept = 01; lane1 map unchanged.
REQ-064 map[1] = 32 ready 0; cdb prn 32 same cycle as reading r1 -> src ready 1; next cycle ready[1] = 1.
REQ-065 After renames, squash with rrat_map[i] = i+100 -> rename_accept 0, fl_pop_en 0; next cycle src r4 -> PRN 104 ready 1; assert reset mid-cycle -> map[i] = i immediately.
